// File: rtl/tft_pkg.sv
// ============================================================================
// Module   : tft_pkg
// Purpose  : Shared constants and types for the TFT bus arbiter slice:
//            arbiter state encoding, TFT byte width, dc polarities and
//            requester index assignments.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tft_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } tft_arb_state_t;

  localparam int TFT_DATA_W = 8;

  // dc line polarity on the TFT interface
  localparam logic TFT_DC_CMD  = 1'b0;
  localparam logic TFT_DC_DATA = 1'b1;

  // Requester slots; index 0 has the highest fixed priority
  localparam int REQ_INIT   = 0;
  localparam int REQ_SCENE  = 1;
  localparam int REQ_SPRITE = 2;

endpackage

`default_nettype wire

// File: rtl/tft_arb_pick.sv
// ============================================================================
// Module   : tft_arb_pick
// Purpose  : Combinational one-hot picker choosing the next bus owner.
//            Default: lowest requesting index wins.
//            With TFT_ARB_ROUND_ROBIN_EN defined: search starts at the index
//            after the last owner and wraps modulo N_REQ.
// Ports    : req      - request vector
//            last     - index of the previous owner
//            pick     - one-hot winner (all zero when req is zero)
//            pick_idx - binary index of the winner
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tft_arb_pick
  import tft_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

`ifdef TFT_ARB_ROUND_ROBIN_EN
  always_comb begin
    int cand;
    pick     = '0;
    pick_idx = '0;
    cand     = 0;
    // Walk from last+1 around to last itself; first hit wins
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      if ((pick == '0) && req[cand]) begin
        pick[cand] = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    // Scan downward so the lowest set index is the final assignment
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick     = '0;
        pick[i]  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/tft_bus_arbiter.sv
// ============================================================================
// Module   : tft_bus_arbiter
// Purpose  : Burst-level arbiter sharing one SPI TFT byte transmitter among
//            N_REQ requesters. An owner keeps the bus for its whole burst so
//            window commands and pixel streams never interleave.
//            Optional macro TFT_ARB_ROUND_ROBIN_EN selects round-robin
//            selection instead of fixed lowest-index priority.
// Ports    : clk, rst (async, active-low)
//            req/req_dc/req_data/req_transmit - per-requester inputs
//            grant (one-hot owner), req_busy (per-requester busy view)
//            tft_busy in; tft_dc/tft_data/tft_transmit registered out
//            bus_idle, protocol_err (sticky)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tft_bus_arbiter
  import tft_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_W     = TFT_DATA_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_dc,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_transmit,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        req_busy,
  input  logic                    tft_busy,
  output logic                    tft_dc,
  output logic [DATA_W-1:0]       tft_data,
  output logic                    tft_transmit,
  output logic                    bus_idle,
  output logic                    protocol_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  tft_arb_state_t    state;
  logic [3:0]        gap_cnt;
  logic [IDX_W-1:0]  last_owner;

  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_strobe;
  logic              owner_req;
  logic              owner_busy;
  logic              owner_dc;
  logic [DATA_W-1:0] owner_data;
  logic              err_now;

  tft_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .last     (last_owner),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // AND-OR mux of the owner's lanes; grant is one-hot or zero
  always_comb begin
    owner_dc   = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner_dc   = req_dc[i];
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign owner_strobe = |(req_transmit & grant);
  assign owner_req    = |(req & grant);
  // tft_transmit covers the cycle before the transmitter raises tft_busy
  assign owner_busy   = tft_busy | tft_transmit;

  assign err_now = (|(req_transmit & ~grant))
                 | (owner_strobe & owner_busy)
                 | ((state == GRANT) & owner_strobe & ~owner_req);

  for (genvar g = 0; g < N_REQ; g++) begin : g_req_busy
    assign req_busy[g] = grant[g] ? owner_busy : 1'b1;
  end

  assign bus_idle = (state == IDLE) & ~tft_transmit & ~tft_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant        <= '0;
      gap_cnt      <= '0;
      last_owner   <= IDX_W'(N_REQ - 1);
      tft_transmit <= 1'b0;
      tft_dc       <= TFT_DC_DATA;
      tft_data     <= '0;
      protocol_err <= 1'b0;
    end else begin
      tft_transmit <= 1'b0;
      if (err_now) begin
        protocol_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (|req) begin
            grant      <= pick;
            last_owner <= pick_idx;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (owner_strobe && !owner_busy) begin
            tft_transmit <= 1'b1;
            tft_dc       <= owner_dc;
            tft_data     <= owner_data;
          end
          // A strobe coinciding with the release is still forwarded above
          if (!owner_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tft_transmit && !tft_busy) begin
            grant   <= '0;
            gap_cnt <= 4'(GAP_CYCLES);
            state   <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tft_bus_arbiter.sv
// ============================================================================
// Module   : tb_tft_bus_arbiter
// Purpose  : Self-checking bench for tft_bus_arbiter: directed scenarios plus
//            randomized traffic compared against a behavioural owner model.
//            Honours TFT_ARB_ROUND_ROBIN_EN for the expected selection order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tft_bus_arbiter;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int GAP = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_dc;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_transmit;
  logic [N-1:0]    grant;
  logic [N-1:0]    req_busy;
  logic            tft_busy;
  logic            tft_dc;
  logic [DW-1:0]   tft_data;
  logic            tft_transmit;
  logic            bus_idle;
  logic            protocol_err;

  tft_bus_arbiter #(
    .N_REQ      (N),
    .DATA_W     (DW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dc       (req_dc),
    .req_data     (req_data),
    .req_transmit (req_transmit),
    .grant        (grant),
    .req_busy     (req_busy),
    .tft_busy     (tft_busy),
    .tft_dc       (tft_dc),
    .tft_data     (tft_data),
    .tft_transmit (tft_transmit),
    .bus_idle     (bus_idle),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner;   // -1 when nobody owns the bus
  bit          m_drain;   // owner released, waiting for transmitter
  int          m_gap;
  int          m_last;
  bit          m_tx;
  bit          m_dc;
  logic [7:0]  m_data;
  bit          m_err;
  int          busy_cnt;

  task automatic model_reset();
    m_owner = -1; m_drain = 0; m_gap = 0; m_last = N - 1;
    m_tx = 0; m_dc = 1; m_data = 8'h00; m_err = 0;
  endtask

  function automatic int choose(input logic [N-1:0] r);
`ifdef TFT_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (r[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // One clock: check combinational views, predict, clock, check registers.
  task automatic step();
    logic [N-1:0] exp_rb;
    int nx_owner, nx_gap, nx_last;
    bit nx_drain, nx_tx, nx_dc, nx_err, ob;
    logic [7:0] nx_data;
    #1;
    ob = tft_busy | m_tx;
    for (int i = 0; i < N; i++) exp_rb[i] = (i == m_owner) ? ob : 1'b1;
    check("req_busy", req_busy, exp_rb);
    check("bus_idle", bus_idle, (m_owner < 0) && !m_tx && !tft_busy);
    nx_owner = m_owner; nx_gap = m_gap; nx_last = m_last; nx_drain = m_drain;
    nx_tx = 0; nx_dc = m_dc; nx_data = m_data; nx_err = m_err;
    for (int i = 0; i < N; i++)
      if (req_transmit[i] && i != m_owner) nx_err = 1;
    if (m_owner >= 0 && req_transmit[m_owner]) begin
      if (ob) nx_err = 1;
      if (!m_drain && !req[m_owner]) nx_err = 1;
    end
    if (m_owner < 0) begin
      if (m_gap > 0) nx_gap = m_gap - 1;
      else if (req != 0) begin nx_owner = choose(req); nx_last = nx_owner; end
    end else if (!m_drain) begin
      if (req_transmit[m_owner] && !ob) begin
        nx_tx = 1; nx_dc = req_dc[m_owner]; nx_data = req_data[m_owner*DW +: DW];
      end
      if (!req[m_owner]) nx_drain = 1;
    end else if (!m_tx && !tft_busy) begin
      nx_owner = -1; nx_drain = 0; nx_gap = GAP;
    end
    @(posedge clk);
    #1;
    m_owner = nx_owner; m_gap = nx_gap; m_last = nx_last; m_drain = nx_drain;
    m_tx = nx_tx; m_dc = nx_dc; m_data = nx_data; m_err = nx_err;
    check("grant", grant, onehot(m_owner));
    check("tft_transmit", tft_transmit, m_tx);
    check("tft_dc", tft_dc, m_dc);
    check("tft_data", tft_data, m_data);
    check("protocol_err", protocol_err, m_err);
  endtask

  // Transmitter stand-in: busy for a few cycles after each strobe
  task automatic xmit_update();
    if (busy_cnt > 0) busy_cnt--;
    if (m_tx) busy_cnt = $urandom_range(1, 4);
    tft_busy = (busy_cnt != 0);
  endtask

  task automatic random_phase(input int cycles, input bit allow_errors);
    for (int c = 0; c < cycles; c++) begin
      req_transmit = '0;
      for (int i = 0; i < N; i++) begin
        if (i == m_owner && !m_drain) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
          else if (!tft_busy && !m_tx && $urandom_range(0, 1) == 1) begin
            req_transmit[i] = 1'b1;
            req_dc[i] = 1'($urandom);
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end else if (i != m_owner) begin
          if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        end
        if (allow_errors && $urandom_range(0, 9) == 0) begin
          req_transmit[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      step();
      xmit_update();
    end
  endtask

  logic [N-1:0] seq_exp [4];
  int           k;

  initial begin
`ifdef TFT_ARB_ROUND_ROBIN_EN
    seq_exp[0] = 3'b001; seq_exp[1] = 3'b010; seq_exp[2] = 3'b100; seq_exp[3] = 3'b001;
`else
    seq_exp[0] = 3'b001; seq_exp[1] = 3'b001; seq_exp[2] = 3'b001; seq_exp[3] = 3'b001;
`endif
    rst = 1'b0; req = '0; req_dc = '0; req_data = '0; req_transmit = '0;
    tft_busy = 1'b0; busy_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 3'b000);
    check("rst_tx", tft_transmit, 1'b0);
    check("rst_dc", tft_dc, 1'b1);
    check("rst_data", tft_data, 8'h00);
    check("rst_err", protocol_err, 1'b0);
    check("rst_idle", bus_idle, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Fixed/initial pick from 110
    req = 3'b110;
    step();
    check("grant_110", grant, 3'b010);

    // Owner 1 sends one data byte
    req_dc = 3'b010; req_data = {8'h00, 8'hFE, 8'h00}; req_transmit = 3'b010;
    step();
    req_transmit = '0;
    check("fe_tx", tft_transmit, 1'b1);
    check("fe_data", tft_data, 8'hFE);
    check("fe_dc", tft_dc, 1'b1);
    check("fe_busy1", req_busy[1], 1'b1);
    tft_busy = 1'b1;
    step();
    check("fe_tx_width", tft_transmit, 1'b0);

    // Owner 1 releases while the transmitter is still busy
    req = 3'b100;
    step();
    repeat (9) step();
    check("drain_hold", grant, 3'b010);
    tft_busy = 1'b0;
    step();
    check("drain_release", grant, 3'b000);
    for (int g = 0; g < GAP; g++) begin
      step();
      check("gap_no_grant", grant, 3'b000);
    end
    step();
    check("gap_then_grant", grant, 3'b100);

    // Let owner 2 go, then all three request at once
    req = 3'b000;
    repeat (4) step();
    req = 3'b111;
    step();
    check("grant_111", grant, 3'b001);

    // Non-owner strobe is ignored and flags an error
    req_transmit = 3'b100;
    step();
    req_transmit = '0;
    check("nonowner_tx", tft_transmit, 1'b0);
    check("nonowner_err", protocol_err, 1'b1);
    step();
    check("err_sticky", protocol_err, 1'b1);

    // Asynchronous reset while a strobe is on the wire
    req_transmit = 3'b001;
    step();
    req_transmit = '0;
    #2;
    rst = 1'b0;
    #1;
    check("async_grant", grant, 3'b000);
    check("async_tx", tft_transmit, 1'b0);
    check("async_err", protocol_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("grant_after_reset", grant, 3'b001);

    // Selection order with all requesters held, one byte per burst
    for (int n = 0; n < 4; n++) begin
      int own;
      check("seq_grant", grant, seq_exp[n]);
      own = m_owner;
      if (own < 0) own = 0;
      req_transmit = onehot(own);
      step();
      req_transmit = '0;
      step();
      req[own] = 1'b0;
      k = 0;
      while (grant != 0 && k < 30) begin step(); k++; end
      check("seq_release", grant, 3'b000);
      req[own] = 1'b1;
      k = 0;
      while (grant == 0 && k < 30) begin step(); k++; end
      check("seq_regrant", grant != 0, 1'b1);
    end

    // Well-behaved random traffic: protocol_err must stay low
    random_phase(600, 1'b0);
    check("clean_err", protocol_err, 1'b0);

    // Clean restart, then traffic with protocol violations mixed in
    @(negedge clk);
    rst = 1'b0; req = '0; req_transmit = '0; tft_busy = 1'b0; busy_cnt = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    random_phase(400, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tft_bus_arbiter.md
Name: tft_bus_arbiter

Overview:
- Shares the single SPI TFT byte transmitter between several drawing requesters: tft init sequencer, scene exhibitor, and sprite/food painters.
- Each requester holds exclusive ownership for a whole burst of command and pixel bytes, so window-set commands and pixel streams are never interleaved.
- Sits between the requesters and the TFT SPI transmitter.
- Registers the selected requester's dc/data/transmit and returns a per-requester busy view.

Parameters:
- N_REQ, 3, number of requesters; index 0 = tft init.
- DATA_W, 8, TFT byte width.
- GAP_CYCLES, 1, idle cycles forced between release and the next grant (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- req  input  N_REQ  ownership request per requester; held for the whole burst
- req_dc  input  N_REQ  dc bit per requester (0 = command, 1 = data)
- req_data  input  N_REQ*DATA_W  byte per requester; requester i occupies bits [i*DATA_W +: DATA_W]
- req_transmit  input  N_REQ  one-cycle send strobe per requester
- grant  output  N_REQ  one-hot owner; all-zero when there is no owner
- req_busy  output  N_REQ  per-requester busy view
- tft_busy  input  1  transmitter busy, from the SPI block
- tft_dc  output  1  registered dc to the transmitter
- tft_data  output  DATA_W  registered byte to the transmitter
- tft_transmit  output  1  registered one-cycle strobe to the transmitter
- bus_idle  output  1  high only in IDLE, with no pending byte and tft_busy low
- protocol_err  output  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; grant = 0; tft_transmit = 0; tft_dc = 1; tft_data = 0; protocol_err = 0; gap counter = 0.
  - Reset mid-burst drops the grant immediately. A byte already inside the transmitter is not the arbiter's concern.
- State machine:
  - IDLE → GRANT: when any req bit is high and the gap counter is 0, the chosen index is registered into grant one-hot. Latency is 1 cycle from req to grant.
  - GRANT: the arbiter forwards only the owner's strobe. On owner req_transmit = 1 and req_busy[owner] = 0, the next edge sets tft_transmit = 1, tft_dc = req_dc[owner], tft_data = owner slice. tft_transmit falls the following cycle (exactly 1 cycle wide).
  - GRANT → DRAIN: when req[owner] falls.
  - DRAIN: grant stays asserted. Exit to IDLE when tft_transmit = 0 and tft_busy = 0. Loading GAP_CYCLES into the gap counter at that point.
  - IDLE: the gap counter decrements to 0. No grant is issued while it is nonzero.
- req_busy:
  - For the owner: tft_busy | tft_transmit. This covers the cycle before the transmitter raises busy.
  - For every non-owner: always 1.
- Selection: fixed priority, lowest index wins. Ties are resolved in the same cycle. A higher-priority request never pre-empts an active owner.
- protocol_err is set in any of these cases:
  - req_transmit from a non-owner;
  - owner strobes while its req_busy = 1;
  - owner drops req in the same cycle as its req_transmit. That strobe is still forwarded, then DRAIN follows.
- A req pulse shorter than 1 cycle while another requester is the owner is simply lost. Requesters must hold req.
- Simultaneous owner release and new requests: the release wins. The new grant comes only after DRAIN and the gap, never in the same cycle.

Optional Feature:
- Macro: TFT_ARB_ROUND_ROBIN_EN.
- Defined: round-robin selection. Priority starts at the index after the last owner, wrapping modulo N_REQ. After reset the last owner is N_REQ-1, so index 0 wins first.
- Not defined: fixed lowest-index priority as described in Behaviour.

Decomposition:
- Shared package tft_pkg holds:
  - state encoding: IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2;
  - TFT_DATA_W = 8;
  - TFT_DC_CMD = 0 and TFT_DC_DATA = 1;
  - requester index constants: REQ_INIT = 0, REQ_SCENE = 1, REQ_SPRITE = 2.
- One sub-module, tft_arb_pick: combinational one-hot picker taking req and last owner, with the round-robin logic under the macro.
- FSM, gap counter and output registers stay in tft_bus_arbiter.

Test Plan:
- Reset then req = 3'b110 → grant = 3'b010 one cycle later. req = 3'b111 in IDLE → grant = 3'b001.
- Owner 1 strobes data 8'hFE, dc = 1 → next cycle tft_transmit = 1, tft_data = 8'hFE, tft_dc = 1, req_busy[1] = 1. Strobe is 1 cycle wide.
- Owner 1 drops req while tft_busy = 1 for 10 cycles → grant held through DRAIN, released after tft_busy falls. With req[2] high, grant = 3'b100 after GAP_CYCLES + 1 more cycles.
- Requester 2 strobes while owner is 1 → tft_transmit stays 0 and protocol_err = 1 until reset.
- rst low mid-burst, asynchronous to clk → grant = 0 and tft_transmit = 0 immediately. After release, a new grant follows.
- With TFT_ARB_ROUND_ROBIN_EN, req = 3'b111 held and each owner releasing after one byte → grant sequence 001, 010, 100, 001.
